// File: rtl/tortoise_pkg.sv
// tortoise_pkg: shared fetch-stage types, sizes and the redirect predicate.
package tortoise_pkg;
    localparam int INSTR_PER_FETCH   = 2;
    localparam int FETCH_QUEUE_DEPTH = 8;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;
    typedef enum logic [1:0] {NO_BRANCH, BRANCH, JAL, JALR} cf_t;
    typedef struct packed {
        cf_t   cf;
        logic  is_taken;
        addr_t target_addr;
    } sbe_predict_t;
    typedef struct packed {
        addr_t        pc;
        instr_t       instr;
        sbe_predict_t predict;
    } fetch_entry_t;
    // A slot only steers fetch when it is a real control-flow op predicted taken.
    function automatic logic redirects(sbe_predict_t p);
        return p.is_taken && p.cf != NO_BRANCH;
    endfunction
endpackage

// File: rtl/fetch_compactor.sv
// fetch_compactor: truncates a fetch bundle after the first taken slot and packs survivors.
// Ports: mask/pc/instr/predict = per-slot bundle in; kept_cnt = survivors; taken/target =
// first taken valid slot and its target; entries = survivors packed from index 0 upward.
module fetch_compactor
    import tortoise_pkg::*;
#(
    parameter int NR_INSTR = INSTR_PER_FETCH,
    localparam int KW = $clog2(NR_INSTR + 1)
) (
    input  logic [NR_INSTR-1:0] mask,
    input  addr_t               pc      [NR_INSTR],
    input  instr_t              instr   [NR_INSTR],
    input  sbe_predict_t        predict [NR_INSTR],
    output logic [KW-1:0]       kept_cnt,
    output logic                taken,
    output addr_t               target,
    output fetch_entry_t        entries [NR_INSTR]
);
    logic [NR_INSTR-1:0] kept;
    logic [KW-1:0]       pos [NR_INSTR];

    // pos[i] is the destination of slot i: the number of kept slots below it.
    always_comb begin
        kept     = '0;
        pos      = '{default: '0};
        kept_cnt = '0;
        taken    = 1'b0;
        target   = '0;
        for (int i = 0; i < NR_INSTR; i++) begin
            pos[i]   = kept_cnt;
            kept[i]  = mask[i] && !taken;
            kept_cnt = kept_cnt + KW'(kept[i]);
            if (kept[i] && redirects(predict[i])) begin
                taken  = 1'b1;
                target = predict[i].target_addr;
            end
        end
    end

    always_comb begin
        entries = '{default: '0};
        for (int j = 0; j < NR_INSTR; j++)
            for (int i = 0; i < NR_INSTR; i++)
                if (kept[i] && pos[i] == KW'(j))
                    entries[j] = '{pc: pc[i], instr: instr[i], predict: predict[i]};
    end
endmodule

// File: rtl/fetch_instr_queue.sv
// fetch_instr_queue: circular instruction FIFO between branch scan and decode.
// Ports: fetch_* = bundle in with ready; redirect_* = taken-branch restart; issue_* = head
// out with valid/ready; flush_i empties the queue; count_o = occupied entries.
module fetch_instr_queue
    import tortoise_pkg::*;
#(
    parameter int NR_INSTR = INSTR_PER_FETCH,
    parameter int DEPTH    = FETCH_QUEUE_DEPTH,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1,
    localparam int KW = $clog2(NR_INSTR + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                fetch_valid_i,
    output logic                fetch_ready_o,
    input  logic [NR_INSTR-1:0] fetch_mask_i,
    input  addr_t               fetch_pc_i    [NR_INSTR],
    input  instr_t              instr_i       [NR_INSTR],
    input  sbe_predict_t        sbe_predict_i [NR_INSTR],
    output logic                redirect_valid_o,
    output addr_t               redirect_pc_o,
    output logic                issue_valid_o,
    input  logic                issue_ready_i,
    output addr_t               issue_pc_o,
    output instr_t              issue_instr_o,
    output sbe_predict_t        issue_predict_o,
    output logic [CW-1:0]       count_o
);
    fetch_entry_t  mem [DEPTH];
    fetch_entry_t  entries [NR_INSTR];
    fetch_entry_t  head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [KW-1:0] kept_cnt;
    logic          taken, accept, dequeue;
    addr_t         target;

    fetch_compactor #(.NR_INSTR(NR_INSTR)) u_compactor (
        .mask(fetch_mask_i), .pc(fetch_pc_i), .instr(instr_i), .predict(sbe_predict_i),
        .kept_cnt(kept_cnt), .taken(taken), .target(target), .entries(entries)
    );

    // Ready reserves room for a whole bundle from the current count only.
    assign fetch_ready_o    = !flush_i && (CW'(DEPTH) - count_o >= CW'(NR_INSTR));
    assign accept           = fetch_valid_i && fetch_ready_o;
    assign redirect_valid_o = accept && taken;
    assign redirect_pc_o    = redirect_valid_o ? target : '0;
    assign issue_valid_o    = count_o != '0;
    assign dequeue          = issue_valid_o && issue_ready_i;
    assign head             = issue_valid_o ? mem[rd_ptr] : '0;
    assign issue_pc_o       = head.pc;
    assign issue_instr_o    = head.instr;
    assign issue_predict_o  = head.predict;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            wr_ptr  <= wr_ptr + (accept ? PW'(kept_cnt) : '0);
            rd_ptr  <= rd_ptr + PW'(dequeue);
            count_o <= count_o + (accept ? CW'(kept_cnt) : '0) - CW'(dequeue);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept)
            for (int j = 0; j < NR_INSTR; j++)
                if (KW'(j) < kept_cnt)
                    mem[wr_ptr + PW'(j)] <= entries[j];
    end
endmodule

// File: tb/tb_fetch_instr_queue.sv
// tb_fetch_instr_queue: directed and random checks of fetch_instr_queue against a queue model.
module tb_fetch_instr_queue;
    import tortoise_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i, flush_i, valid, iready;
    logic [1:0]   mask;
    addr_t        pc    [2];
    instr_t       instr [2];
    sbe_predict_t pred  [2];
    logic         fetch_ready_o, redirect_valid_o, issue_valid_o;
    addr_t        redirect_pc_o, issue_pc_o;
    instr_t       issue_instr_o;
    sbe_predict_t issue_predict_o;
    logic [3:0]   count_o;

    fetch_entry_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_instr_queue #(.NR_INSTR(2), .DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .fetch_valid_i(valid), .fetch_ready_o(fetch_ready_o), .fetch_mask_i(mask),
        .fetch_pc_i(pc), .instr_i(instr), .sbe_predict_i(pred),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .issue_valid_o(issue_valid_o), .issue_ready_i(iready),
        .issue_pc_o(issue_pc_o), .issue_instr_o(issue_instr_o),
        .issue_predict_o(issue_predict_o), .count_o(count_o)
    );

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic sbe_predict_t mkp(cf_t cf, logic t, addr_t a);
        return '{cf: cf, is_taken: t, target_addr: a};
    endfunction

    task automatic bund(logic v, logic [1:0] m, addr_t p0, sbe_predict_t a, sbe_predict_t b);
        valid = v; mask = m; pc[0] = p0; pc[1] = p0 + 4;
        instr[0] = $urandom; instr[1] = $urandom; pred[0] = a; pred[1] = b;
    endtask

    // Model: the queue is a list of entries; each cycle compare, then apply the cycle's effect.
    task automatic step();
        int k;
        logic exp_ready, acc;
        addr_t exp_pc;
        fetch_entry_t h;
        #1;
        k = -1;
        for (int i = 0; i < 2; i++)
            if (k < 0 && mask[i] && pred[i].is_taken && pred[i].cf != NO_BRANCH) k = i;
        exp_ready = !flush_i && (8 - q.size() >= 2);
        acc = valid && exp_ready;
        exp_pc = '0;
        if (acc && k >= 0) exp_pc = pred[k].target_addr;
        h = (q.size() != 0) ? q[0] : '0;
        chk("fetch_ready", fetch_ready_o, exp_ready);
        chk("count", count_o, q.size());
        chk("issue_valid", issue_valid_o, q.size() != 0);
        chk("issue_pc", issue_pc_o, h.pc);
        chk("issue_instr", issue_instr_o, h.instr);
        chk("issue_predict", issue_predict_o, h.predict);
        chk("redirect_valid", redirect_valid_o, acc && k >= 0);
        chk("redirect_pc", redirect_pc_o, exp_pc);
        if (flush_i) q.delete();
        else begin
            if (q.size() != 0 && iready) void'(q.pop_front());
            if (acc)
                for (int i = 0; i < 2; i++)
                    if (mask[i] && (k < 0 || i <= k))
                        q.push_back('{pc: pc[i], instr: instr[i], predict: pred[i]});
        end
        @(negedge clk);
    endtask

    initial begin
        sbe_predict_t nt;
        nt = mkp(NO_BRANCH, 1'b0, '0);
        rst_i = 1'b1; flush_i = 1'b0; iready = 1'b0;
        bund(1'b0, 2'b00, '0, nt, nt);
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        #1;
        chk("rst_count", count_o, 0);
        chk("rst_issue_valid", issue_valid_o, 0);
        chk("rst_ready", fetch_ready_o, 1);
        chk("rst_issue_pc", issue_pc_o, 0);
        @(negedge clk);

        bund(1'b1, 2'b11, 32'h100, nt, nt);
        #1 chk("t2_no_redirect", redirect_valid_o, 0);
        step();
        valid = 1'b0;
        #1 chk("t2_count", count_o, 2);
        chk("t2_head0", issue_pc_o, 32'h100);
        iready = 1'b1;
        step();
        #1 chk("t2_head1", issue_pc_o, 32'h104);
        step();

        iready = 1'b0;
        bund(1'b1, 2'b11, 32'h100, mkp(BRANCH, 1'b1, 32'h200), nt);
        #1 chk("t3_rv", redirect_valid_o, 1);
        chk("t3_rpc", redirect_pc_o, 32'h200);
        step();
        valid = 1'b0;
        #1 chk("t3_count", count_o, 1);
        chk("t3_head", issue_pc_o, 32'h100);
        iready = 1'b1;
        step();

        iready = 1'b0;
        bund(1'b1, 2'b10, 32'h100, mkp(JAL, 1'b1, 32'h999), mkp(JAL, 1'b1, 32'h300));
        #1 chk("t4_rv", redirect_valid_o, 1);
        chk("t4_rpc", redirect_pc_o, 32'h300);
        step();
        valid = 1'b0;
        #1 chk("t4_count", count_o, 1);
        chk("t4_head", issue_pc_o, 32'h104);
        iready = 1'b1;
        step();

        iready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            bund(1'b1, 2'b11, 32'h400 + 8 * b, nt, nt);
            step();
        end
        bund(1'b1, 2'b01, 32'h418, nt, nt);
        #1 chk("t5_ready_at6", fetch_ready_o, 1);
        step();
        bund(1'b1, 2'b11, 32'h420, nt, nt);
        #1 chk("t5_count7", count_o, 7);
        chk("t5_ready_full", fetch_ready_o, 0);
        iready = 1'b1;
        step();
        #1 chk("t5_count6", count_o, 6);
        chk("t5_ready_back", fetch_ready_o, 1);
        step();
        valid = 1'b0;
        repeat (9) step();

        iready = 1'b0;
        repeat (2) begin
            bund(1'b1, 2'b11, 32'h500, nt, nt);
            step();
        end
        bund(1'b1, 2'b11, 32'h600, mkp(BRANCH, 1'b1, 32'h700), nt);
        flush_i = 1'b1; iready = 1'b1;
        #1 chk("t6_no_redirect", redirect_valid_o, 0);
        chk("t6_ready_low", fetch_ready_o, 0);
        step();
        flush_i = 1'b0; valid = 1'b0;
        #1 chk("t6_count", count_o, 0);
        chk("t6_issue_valid", issue_valid_o, 0);
        step();

        iready = 1'b0;
        bund(1'b1, 2'b11, 32'h800, nt, nt); step();
        bund(1'b1, 2'b11, 32'h808, nt, nt); step();
        bund(1'b1, 2'b01, 32'h810, nt, nt); step();
        valid = 1'b0;
        #1 chk("t1_pre_count", count_o, 5);
        rst_i = 1'b1;
        #1 chk("t1_count", count_o, 0);
        chk("t1_issue_valid", issue_valid_o, 0);
        chk("t1_ready", fetch_ready_o, 1);
        q.delete();
        #1 rst_i = 1'b0;
        @(negedge clk);

        for (int c = 0; c < 800; c++) begin
            valid = $urandom_range(0, 9) < 7;
            mask = 2'($urandom);
            pc[0] = $urandom & 32'hffff_fffc;
            pc[1] = pc[0] + 4;
            for (int i = 0; i < 2; i++) begin
                instr[i] = $urandom;
                pred[i] = mkp(cf_t'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom & 32'hffff_fffe);
            end
            iready = (c < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
            flush_i = $urandom_range(0, 39) == 0;
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
